// File: rtl/mcp3008_pkg.sv
// Shared types, frame constants and the raw-to-accel mapping for the MCP3008 reader.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  // Command start bit, driven for the whole SETUP phase.
  localparam logic CMD_START = 1'b1;

  // Frame geometry: 17 SCLK periods, conversion data sampled on rising edges 8..17.
  localparam int unsigned SCLK_PERIODS    = 17;
  localparam int unsigned FIRST_DATA_EDGE = 8;

  // Dead band below lo, saturation at/above hi, slope of 2 in between.
  // Computed in 11 bits and truncated to 10.
  function automatic logic [9:0] accel_map(input logic [9:0] raw, input logic [9:0] lo,
                                           input logic [9:0] hi, input logic [9:0] max);
    if (raw <= lo)
      return '0;
    else if (raw >= hi)
      return max;
    else
      return 10'(({1'b0, raw} - {1'b0, lo}) << 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter with rise/fall strobes announcing the next edge.
module spi_sclk_gen #(
  parameter int unsigned HALF_DIV = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold_low,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic period_end
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  // Last cycle of the current half-period; strobes are valid in this cycle.
  always_comb begin
    tick       = run && (cnt == CW'(HALF_DIV - 1));
    rise       = tick && !sclk && !hold_low;
    fall       = tick && sclk;
    period_end = tick && !sclk;
  end

  // Half-period counter and SCLK toggle; idle low whenever run is deasserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      if (sclk)
        sclk <= 1'b0;
      else if (!hold_low)
        sclk <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcp3008_accel_reader.sv
// MCP3008 SPI frame engine: reads one channel continuously and maps it to a clamped accel value.
module mcp3008_accel_reader
  import mcp3008_pkg::*;
#(
  parameter int unsigned HALF_DIV  = 14,
  parameter int unsigned CHANNEL   = 5,
  parameter int unsigned SGL       = 1,
  parameter int unsigned GAP_CYC   = 16,
  parameter int unsigned LO_THRESH = 280,
  parameter int unsigned HI_THRESH = 780,
  parameter int unsigned ACCEL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       AD_CLK,
  output logic       CS,
  output logic       DIN,
  input  logic       DOUT,
  output logic [9:0] sample,
  output logic [9:0] accel,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [2:0]  CH_BITS  = 3'(CHANNEL);
  localparam logic        SGL_BIT  = 1'(SGL);
  localparam logic [4:0]  K_LAST   = 5'(SCLK_PERIODS);
  localparam logic [4:0]  K_DATA   = 5'(FIRST_DATA_EDGE - 1);

  state_t        state, state_n;
  logic [4:0]    k, k_n;
  logic [9:0]    sr, sr_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          cs_n, din_n, valid_n;
  logic [9:0]    sample_n, accel_n;
  logic          run, hold_low;
  logic          rise, fall, period_end;

  // SCLK runs through SETUP (pre-rise low phase) and SHIFT; rises stop after period 17.
  assign run      = (state == ST_SETUP) || (state == ST_SHIFT);
  assign hold_low = (state == ST_SHIFT) && (k == K_LAST);

  spi_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .hold_low  (hold_low),
    .sclk      (AD_CLK),
    .rise      (rise),
    .fall      (fall),
    .period_end(period_end)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    k_n      = k;
    sr_n     = sr;
    gcnt_n   = gcnt;
    cs_n     = CS;
    din_n    = DIN;
    sample_n = sample;
    accel_n  = accel;
    valid_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        cs_n  = 1'b1;
        din_n = 1'b0;
        if (en) begin
          state_n = ST_SETUP;
          cs_n    = 1'b0;
          din_n   = CMD_START;
          sr_n    = '0;
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_n = ST_SHIFT;
          k_n     = 5'd1;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          k_n = k + 5'd1;
          if (k >= K_DATA)
            sr_n = {sr[8:0], DOUT};
        end
        if (fall) begin
          case (k)
            5'd1:    din_n = SGL_BIT;
            5'd2:    din_n = CH_BITS[2];
            5'd3:    din_n = CH_BITS[1];
            5'd4:    din_n = CH_BITS[0];
            default: din_n = 1'b0;
          endcase
        end
        if (period_end && hold_low) begin
          state_n = ST_DONE;
          cs_n    = 1'b1;
        end
      end
      ST_DONE: begin
        sample_n = sr;
        accel_n  = accel_map(sr, 10'(LO_THRESH), 10'(HI_THRESH), 10'(ACCEL_MAX));
        valid_n  = 1'b1;
        gcnt_n   = '0;
        state_n  = ST_GAP;
      end
      ST_GAP: begin
        if (gcnt == GW'(GAP_CYC - 1)) begin
          gcnt_n = '0;
          if (en) begin
            state_n = ST_SETUP;
            cs_n    = 1'b0;
            din_n   = CMD_START;
            sr_n    = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cs_n    = 1'b1;
        din_n   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame and clears results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      sr     <= '0;
      gcnt   <= '0;
      CS     <= 1'b1;
      DIN    <= 1'b0;
      sample <= '0;
      accel  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      sr     <= sr_n;
      gcnt   <= gcnt_n;
      CS     <= cs_n;
      DIN    <= din_n;
      sample <= sample_n;
      accel  <= accel_n;
      valid  <= valid_n;
      busy   <= ~cs_n;
    end
  end

endmodule

// File: tb/tb_mcp3008_accel_reader.sv
// Directed bench for mcp3008_accel_reader: default instance plus a fast HALF_DIV=2 instance.
module tb_mcp3008_accel_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic       DOUT0 = 1'b0, DOUT1 = 1'b0;
  logic       AD_CLK0, CS0, DIN0, valid0, busy0;
  logic       AD_CLK1, CS1, DIN1, valid1, busy1;
  logic [9:0] sample0, accel0, sample1, accel1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcp3008_accel_reader u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .AD_CLK(AD_CLK0), .CS(CS0), .DIN(DIN0), .DOUT(DOUT0),
    .sample(sample0), .accel(accel0), .valid(valid0), .busy(busy0)
  );

  mcp3008_accel_reader #(.HALF_DIV(2), .CHANNEL(0), .SGL(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .AD_CLK(AD_CLK1), .CS(CS1), .DIN(DIN1), .DOUT(DOUT1),
    .sample(sample1), .accel(accel1), .valid(valid1), .busy(busy1)
  );

  // ADC models: after falling edge j, present the bit sampled on rising edge j+1.
  logic [9:0] raw0 = '0, raw1 = '0;
  int rcnt0 = 0, fcnt0 = 0, rise_total0 = 0;
  int rcnt1 = 0, fcnt1 = 0;
  logic [4:0] dseq0 = '0, dseq1 = '0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  always @(negedge clk) begin
    if (!prev0 && AD_CLK0) begin
      rise_total0++;
      rcnt0++;
      if (rcnt0 <= 5) dseq0 = {dseq0[3:0], DIN0};
    end
    if (CS0) begin
      rcnt0 = 0; fcnt0 = 0; DOUT0 = 1'b0;
    end else if (prev0 && !AD_CLK0) begin
      fcnt0++;
      if (fcnt0 >= 7 && fcnt0 <= 16) DOUT0 = raw0[16 - fcnt0];
      else DOUT0 = 1'b0;
    end
    prev0 = AD_CLK0;
  end

  always @(negedge clk) begin
    if (!prev1 && AD_CLK1) begin
      rcnt1++;
      if (rcnt1 <= 5) dseq1 = {dseq1[3:0], DIN1};
    end
    if (CS1) begin
      rcnt1 = 0; fcnt1 = 0; DOUT1 = 1'b0;
    end else if (prev1 && !AD_CLK1) begin
      fcnt1++;
      if (fcnt1 >= 7 && fcnt1 <= 16) DOUT1 = raw1[16 - fcnt1];
      else DOUT1 = 1'b0;
    end
    prev1 = AD_CLK1;
  end

  // One frame on instance 0; lat = negedges from first CS-low sample to valid.
  task automatic do_frame0(input logic [9:0] r, output int lat);
    int n;
    raw0 = r;
    @(negedge clk);
    en0 = 1'b1;
    n = 0;
    while (CS0 && n < 200) begin @(negedge clk); n++; end
    if (CS0) begin
      checks++; failures++;
      $display("FAIL frame_start: CS never went low for raw=%0d", r);
      en0 = 1'b0; lat = -1;
      return;
    end
    en0 = 1'b0;
    lat = 0;
    while (!valid0 && lat < 2000) begin @(negedge clk); lat++; end
    if (!valid0) begin
      checks++; failures++;
      $display("FAIL frame_valid: no valid within %0d cycles for raw=%0d", lat, r);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({CS0, AD_CLK0, DIN0, valid0, busy0} !== 5'b10000) begin
      failures++; $display("FAIL reset_ctrl: got %b want 10000", {CS0, AD_CLK0, DIN0, valid0, busy0});
    end
    checks++;
    if (sample0 !== 10'd0 || accel0 !== 10'd0) begin
      failures++; $display("FAIL reset_data: sample=%0d accel=%0d want 0/0", sample0, accel0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (CS0 !== 1'b1 || AD_CLK0 !== 1'b0) begin
      failures++; $display("FAIL idle_no_en: CS=%b AD_CLK=%b want 1/0", CS0, AD_CLK0);
    end
  endtask

  task automatic test_first_frame();
    int lat;
    do_frame0(10'h3FF, lat);
    checks++;
    if (lat !== 491) begin failures++; $display("FAIL latency: got %0d want 491", lat); end
    checks++;
    if (dseq0 !== 5'b11101) begin failures++; $display("FAIL din_cmd: got %b want 11101", dseq0); end
    checks++;
    if (sample0 !== 10'd1023) begin failures++; $display("FAIL sample_max: got %0d want 1023", sample0); end
    checks++;
    if (accel0 !== 10'd1000) begin failures++; $display("FAIL accel_max: got %0d want 1000", accel0); end
    checks++;
    if (busy0 !== 1'b0 || CS0 !== 1'b1) begin
      failures++; $display("FAIL done_cs: CS=%b busy=%b want 1/0", CS0, busy0);
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0) begin failures++; $display("FAIL valid_width: got %b want 0", valid0); end
    repeat (25) @(negedge clk);
    checks++;
    if (CS0 !== 1'b1 || sample0 !== 10'd1023) begin
      failures++; $display("FAIL idle_hold: CS=%b sample=%0d want 1/1023", CS0, sample0);
    end
  endtask

  task automatic test_mapping();
    logic [9:0] raws [7] = '{10'd279, 10'd280, 10'd281, 10'd530, 10'd779, 10'd780, 10'd781};
    logic [9:0] exps [7] = '{10'd0, 10'd0, 10'd2, 10'd500, 10'd998, 10'd1000, 10'd1000};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_frame0(raws[i], lat);
      checks++;
      if (sample0 !== raws[i] || accel0 !== exps[i]) begin
        failures++;
        $display("FAIL map_%0d: sample=%0d accel=%0d want %0d/%0d", raws[i], sample0, accel0, raws[i], exps[i]);
      end
      repeat (25) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] nxt [3] = '{10'd600, 10'd900, 10'd0};
    logic [9:0] exps [3] = '{10'd0, 10'd640, 10'd1000};
    int cyc = 0, last = 0, v = 0, hs = 0;
    bit started = 0;
    raw0 = 10'd100;
    @(negedge clk);
    en0 = 1'b1;
    while (v < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!CS0) begin
        if (started && hs > 0) begin
          checks++;
          if (hs < 16) begin failures++; $display("FAIL gap_len: got %0d want >=16", hs); end
        end
        started = 1; hs = 0;
      end else if (started) begin
        hs++;
      end
      if (valid0) begin
        checks++;
        if (accel0 !== exps[v]) begin
          failures++; $display("FAIL b2b_accel_%0d: got %0d want %0d", v, accel0, exps[v]);
        end
        if (v > 0) begin
          checks++;
          if (cyc - last !== 507) begin
            failures++; $display("FAIL b2b_spacing_%0d: got %0d want 507", v, cyc - last);
          end
        end
        last = cyc;
        raw0 = nxt[v];
        v++;
      end
    end
    en0 = 1'b0;
    if (v < 3) begin
      checks++; failures++;
      $display("FAIL b2b_count: got %0d valid pulses want 3", v);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_en_drop();
    int n = 0, nvalid = 0, rises_at_valid = 0, cs_low_after = 0;
    bit seen = 0;
    raw0 = 10'd700;
    @(negedge clk);
    en0 = 1'b1;
    while (rcnt0 < 10 && n < 1000) begin @(negedge clk); n++; end
    en0 = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (valid0) begin nvalid++; seen = 1; rises_at_valid = rise_total0; end
      else if (seen && !CS0) cs_low_after++;
    end
    checks++;
    if (nvalid !== 1) begin failures++; $display("FAIL drop_valid_count: got %0d want 1", nvalid); end
    checks++;
    if (sample0 !== 10'd700 || accel0 !== 10'd840) begin
      failures++; $display("FAIL drop_data: sample=%0d accel=%0d want 700/840", sample0, accel0);
    end
    checks++;
    if (cs_low_after !== 0 || rise_total0 !== rises_at_valid) begin
      failures++;
      $display("FAIL drop_idle: cs_low=%0d extra_rises=%0d want 0/0", cs_low_after, rise_total0 - rises_at_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, lat, vseen = 0;
    raw0 = 10'h2AA;
    @(negedge clk);
    en0 = 1'b1;
    while (rcnt0 < 12 && n < 1000) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (CS0 !== 1'b1 || AD_CLK0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ctrl: CS=%b AD_CLK=%b busy=%b want 1/0/0", CS0, AD_CLK0, busy0);
    end
    checks++;
    if (sample0 !== 10'd0 || accel0 !== 10'd0) begin
      failures++; $display("FAIL rst_mid_data: sample=%0d accel=%0d want 0/0", sample0, accel0);
    end
    repeat (3) begin @(negedge clk); if (valid0) vseen++; end
    rst = 1'b0;
    do_frame0(10'h155, lat);
    checks++;
    if (vseen !== 0 || lat !== 491) begin
      failures++; $display("FAIL rst_mid_recover_timing: valid_in_rst=%0d lat=%0d want 0/491", vseen, lat);
    end
    checks++;
    if (sample0 !== 10'h155 || accel0 !== 10'd122) begin
      failures++; $display("FAIL rst_mid_recover_data: sample=%0d accel=%0d want 341/122", sample0, accel0);
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_fast_div();
    int n = 0, lat = 0, t_rise = -1, t_fall = -1;
    raw1 = 10'd496;
    @(negedge clk);
    en1 = 1'b1;
    while (CS1 && n < 50) begin @(negedge clk); n++; end
    en1 = 1'b0;
    while (!valid1 && lat < 500) begin
      @(negedge clk);
      lat++;
      if (AD_CLK1 && t_rise < 0) t_rise = lat;
      if (!AD_CLK1 && t_rise >= 0 && t_fall < 0) t_fall = lat;
    end
    checks++;
    if (lat !== 71) begin failures++; $display("FAIL fast_latency: got %0d want 71", lat); end
    checks++;
    if (t_rise !== 2 || t_fall - t_rise !== 2) begin
      failures++; $display("FAIL fast_half_period: setup=%0d high=%0d want 2/2", t_rise, t_fall - t_rise);
    end
    checks++;
    if (dseq1 !== 5'b10000) begin failures++; $display("FAIL fast_din_cmd: got %b want 10000", dseq1); end
    checks++;
    if (sample1 !== 10'd496 || accel1 !== 10'd432) begin
      failures++; $display("FAIL fast_data: sample=%0d accel=%0d want 496/432", sample1, accel1);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_mapping();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_fast_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
